// File: rtl/player_control.sv
// Paddle position generator for two players.
// Buttons and vsync are synchronised; both paddles advance once per frame.
module player_control #(
    parameter int POS_MIN      = 0,
    parameter int POS_MAX      = 416,
    parameter int POS_RESET    = 208,
    parameter int SPEED_MIN    = 2,
    parameter int SPEED_MAX    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       btn_up1,
    input  logic       btn_dn1,
    input  logic       btn_up2,
    input  logic       btn_dn2,
    output logic [9:0] pos_ply1,
    output logic [9:0] pos_ply2,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN
    } state_t;

    localparam logic signed [10:0] PMIN   = 11'(POS_MIN);
    localparam logic signed [10:0] PMAX   = 11'(POS_MAX);
    localparam logic [9:0]         PRST   = 10'(POS_RESET);
    localparam logic [3:0]         SMIN   = 4'(SPEED_MIN);
    localparam logic [3:0]         SMAX   = 4'(SPEED_MAX);
    localparam logic [8:0]         ACCEL  = 9'(ACCEL_FRAMES);

    logic       vs_s1, vs_s2, vs_s3;
    logic [1:0] fill;
    logic [1:0] up_s1, up_s2, dn_s1, dn_s2;

    // s3 holds its reset value until s2 carries a real sample, so a vsync
    // that is already high when reset is released never produces a tick.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b1;
            fill  <= 2'b00;
            up_s1 <= 2'b00;
            up_s2 <= 2'b00;
            dn_s1 <= 2'b00;
            dn_s2 <= 2'b00;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            fill  <= {fill[0], 1'b1};
            if (fill[1]) vs_s3 <= vs_s2;
            up_s1 <= {btn_up2, btn_up1};
            up_s2 <= up_s1;
            dn_s1 <= {btn_dn2, btn_dn1};
            dn_s2 <= dn_s1;
        end
    end

    assign frame_tick = vs_s2 & ~vs_s3;

    state_t                st      [2];
    logic [9:0]            pos     [2];
    logic [3:0]            spd     [2];
    logic [7:0]            cnt     [2];

    state_t                req     [2];
    logic                  fresh   [2];
    logic [3:0]            spd_use [2];
    logic [8:0]            cnt_inc [2];
    logic signed [10:0]    raw     [2];
    logic [9:0]            pos_nxt [2];
    logic [3:0]            spd_nxt [2];
    logic [7:0]            cnt_nxt [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req[i] = IDLE;
            if (up_s2[i] && !dn_s2[i])      req[i] = MOVE_UP;
            else if (dn_s2[i] && !up_s2[i]) req[i] = MOVE_DOWN;

            // A new direction restarts the ramp and counts as its first frame.
            fresh[i]   = (req[i] != st[i]);
            spd_use[i] = fresh[i] ? SMIN : spd[i];
            cnt_inc[i] = (fresh[i] ? 9'd0 : {1'b0, cnt[i]}) + 9'd1;

            if (req[i] == MOVE_UP)
                raw[i] = signed'({1'b0, pos[i]}) - signed'({7'b0, spd_use[i]});
            else
                raw[i] = signed'({1'b0, pos[i]}) + signed'({7'b0, spd_use[i]});

            pos_nxt[i] = raw[i][9:0];
            if (raw[i] < PMIN)      pos_nxt[i] = PMIN[9:0];
            else if (raw[i] > PMAX) pos_nxt[i] = PMAX[9:0];

            spd_nxt[i] = spd_use[i];
            cnt_nxt[i] = cnt_inc[i][7:0];
            if (cnt_inc[i] == ACCEL) begin
                cnt_nxt[i] = 8'd0;
                if (spd_use[i] < SMAX) spd_nxt[i] = spd_use[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                st[i]  <= IDLE;
                pos[i] <= PRST;
                spd[i] <= SMIN;
                cnt[i] <= 8'd0;
            end
        end else if (frame_tick) begin
            for (int i = 0; i < 2; i++) begin
                st[i] <= req[i];
                if (req[i] == IDLE) begin
                    spd[i] <= SMIN;
                    cnt[i] <= 8'd0;
                end else begin
                    pos[i] <= pos_nxt[i];
                    spd[i] <= spd_nxt[i];
                    cnt[i] <= cnt_nxt[i];
                end
            end
        end
    end

    assign pos_ply1 = pos[0];
    assign pos_ply2 = pos[1];

endmodule

// File: tb/tb_player_control.sv
// Scoreboard bench for player_control: frame-level reference model,
// expected ticks and positions queued by stimulus, checked by a monitor.
module tb_player_control;

    logic       px_clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       btn_up1, btn_dn1, btn_up2, btn_dn2;
    logic [9:0] pos_ply1, pos_ply2;
    logic       frame_tick;

    player_control dut (
        .px_clk    (px_clk),
        .reset     (reset),
        .vsync     (vsync),
        .btn_up1   (btn_up1),
        .btn_dn1   (btn_dn1),
        .btn_up2   (btn_up2),
        .btn_dn2   (btn_dn2),
        .pos_ply1  (pos_ply1),
        .pos_ply2  (pos_ply2),
        .frame_tick(frame_tick)
    );

    always #5 px_clk = ~px_clk;

    int cyc = 0;
    always @(posedge px_clk) cyc++;

    typedef struct {
        int tcyc;
        int p1;
        int p2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: run length of consecutive moving frames per player.
    int m_pos[2];
    int m_dir[2];
    int m_run[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 208;
            m_dir[i] = 0;
            m_run[i] = 0;
        end
    endfunction

    function automatic void model_step(int i, bit up, bit dn);
        int req;
        int spd;
        req = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
        if (req == 0) begin
            m_dir[i] = 0;
            m_run[i] = 0;
        end else begin
            if (req != m_dir[i]) begin
                m_dir[i] = req;
                m_run[i] = 1;
            end else begin
                m_run[i]++;
            end
            spd = 2 + (m_run[i] - 1) / 4;
            if (spd > 8) spd = 8;
            m_pos[i] = m_pos[i] + req * spd;
            if (m_pos[i] < 0)   m_pos[i] = 0;
            if (m_pos[i] > 416) m_pos[i] = 416;
        end
    endfunction

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                      name, act, req, cyc);
    endtask

    // Monitor
    initial begin
        int  cur1 = 208, cur2 = 208;
        int  pend1 = 0, pend2 = 0;
        bit  have_pend = 0;
        bit  prev_tick = 0;
        exp_t e;
        forever begin
            @(posedge px_clk);
            #1;
            if (reset) begin
                cur1 = 208;
                cur2 = 208;
                have_pend = 0;
                prev_tick = 0;
                chk("reset_pos1", int'(pos_ply1), 208);
                chk("reset_pos2", int'(pos_ply2), 208);
                chk("reset_tick", int'(frame_tick), 0);
            end else begin
                if (prev_tick) chk("tick_width", int'(frame_tick), 0);
                if (have_pend) begin
                    cur1 = pend1;
                    cur2 = pend2;
                    have_pend = 0;
                end
                chk("pos1", int'(pos_ply1), cur1);
                chk("pos2", int'(pos_ply2), cur2);
                if (frame_tick && !prev_tick) begin
                    chk("tick_expected", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("tick_time", cyc, e.tcyc);
                        pend1 = e.p1;
                        pend2 = e.p2;
                        have_pend = 1;
                    end
                end
                prev_tick = frame_tick;
            end
        end
    end

    task automatic frame(input logic [3:0] b, input bit glitch);
        int lo;
        int hi;
        int k;
        logic [3:0] g;
        lo = $urandom_range(6, 12);
        hi = $urandom_range(5, 10);
        @(negedge px_clk);
        vsync = 1'b0;
        {btn_up1, btn_dn1, btn_up2, btn_dn2} = b;
        for (int c = 1; c < lo; c++) begin
            @(negedge px_clk);
            if (glitch && c == 2) begin
                k = $urandom_range(0, 3);
                g = b;
                g[k] = ~g[k];
                {btn_up1, btn_dn1, btn_up2, btn_dn2} = g;
            end
            if (glitch && c == 3)
                {btn_up1, btn_dn1, btn_up2, btn_dn2} = b;
        end
        @(negedge px_clk);
        vsync = 1'b1;
        model_step(0, b[3], b[2]);
        model_step(1, b[1], b[0]);
        q.push_back('{cyc + 2, m_pos[0], m_pos[1]});
        repeat (hi) @(negedge px_clk);
    endtask

    task automatic reset_mid_frame();
        @(negedge px_clk);
        vsync = 1'b0;
        {btn_up1, btn_dn1, btn_up2, btn_dn2} = 4'b1000;
        repeat (8) @(negedge px_clk);
        vsync = 1'b1;
        reset = 1'b1;
        q.delete();
        model_reset();
        repeat (2) @(negedge px_clk);
        reset = 1'b0;
        repeat (10) @(negedge px_clk);
    endtask

    initial begin
        reset = 1'b1;
        vsync = 1'b0;
        {btn_up1, btn_dn1, btn_up2, btn_dn2} = 4'b0000;
        model_reset();
        repeat (3) @(negedge px_clk);
        reset = 1'b0;

        repeat (10) frame(4'b0000, 1'b0);
        repeat (8)  frame(4'b1000, 1'b0);
        // Player 1 continues up to the top; player 2 runs down to the bottom.
        repeat (45) frame(4'b1001, 1'b0);

        repeat (6) frame(4'b1000, 1'b0);
        repeat (3) frame(4'b0100, 1'b0);
        repeat (3) frame(4'b1100, 1'b0);
        repeat (2) frame(4'b0110, 1'b0);

        reset_mid_frame();
        repeat (3) frame(4'b1000, 1'b0);

        repeat (4) frame(4'b0000, 1'b1);
        repeat (3) frame(4'b0101, 1'b1);

        repeat (40) frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        @(negedge px_clk);
        vsync = 1'b0;
        repeat (6) @(negedge px_clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
